phase_control: RTL and testbench



---
 rtl/phase_control.sv | 215 +++++++++++++++++++++
 tb/tb_phase_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_control.sv
// ---------------------------------------------------------------------------
// phase_control
//   Five-phase instruction sequencer and decoder for the 16-bit processor.
//   Steps through P1 fetch, P2 operand read, P3 execute, P4 memory/branch and
//   P5 writeback for each instruction. IDLE and HALT wait for start. All
//   datapath strobes are decoded combinationally from the current phase and ir.
//
//   Optional feature, enabled by defining PHASE_CONTROL_SINGLE_STEP_EN:
//     An extra input 'step' is added. After P5 the sequencer parks in
//     STEP_WAIT and moves on to the next P1 only when step=1.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   start             : level; leaves IDLE/HALT and begins a fetch
//   step              : single-step advance (only with PHASE_CONTROL_SINGLE_STEP_EN)
//   ir[15:0]          : instruction register contents
//   s_in..v_in        : ALU flags, sampled at the end of P3
//   phase[4:0]        : one-hot phase, bit0=P1 .. bit4=P5; 0 when not executing
//   ir_e..mr_e, pc_e  : register load enables
//   pc_ld             : with pc_e, 1 = load DR (branch), 0 = increment
//   alu_e, mem_e      : ALU evaluate enable, memory write strobe
//   reg_read/reg_write: register-file strobes
//   m1_s..m4_s        : datapath mux selects
//   alu_cnt[3:0]      : ALU opcode
//   flags[3:0]        : latched {S,Z,C,V}
//   halted            : high in HALT
// ---------------------------------------------------------------------------
module phase_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef PHASE_CONTROL_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] ir,
    input  logic        s_in,
    input  logic        z_in,
    input  logic        c_in,
    input  logic        v_in,
    output logic [4:0]  phase,
    output logic        ir_e,
    output logic        ar_e,
    output logic        br_e,
    output logic        dr_e,
    output logic        mr_e,
    output logic        pc_e,
    output logic        pc_ld,
    output logic        alu_e,
    output logic        mem_e,
    output logic        reg_read,
    output logic        reg_write,
    output logic        m1_s,
    output logic        m2_s,
    output logic        m3_s,
    output logic        m4_s,
    output logic [3:0]  alu_cnt,
    output logic [3:0]  flags,
    output logic        halted
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] P1        = 3'd1;
    localparam logic [2:0] P2        = 3'd2;
    localparam logic [2:0] P3        = 3'd3;
    localparam logic [2:0] P4        = 3'd4;
    localparam logic [2:0] P5        = 3'd5;
    localparam logic [2:0] HALT      = 3'd6;
`ifdef PHASE_CONTROL_SINGLE_STEP_EN
    localparam logic [2:0] STEP_WAIT = 3'd7;
`endif

    logic [2:0] state, state_next;
    logic       taken;

    // ---------------- instruction decode ----------------
    logic [3:0] op3;
    logic       is_alu, is_ld, is_st, is_li, is_b, is_bc, is_hlt;
    logic       alu_wr, alu_fl, cond_met;
    logic       unused_ir;

    assign op3       = ir[7:4];
    assign is_alu    = (ir[15:14] == 2'b11);
    assign is_ld     = (ir[15:14] == 2'b00);
    assign is_st     = (ir[15:14] == 2'b01);
    assign is_li     = (ir[15:11] == 5'b10000);
    assign is_b      = (ir[15:11] == 5'b10100);
    assign is_bc     = (ir[15:11] == 5'b10111);
    assign is_hlt    = is_alu && (op3 == 4'b1111);
    assign unused_ir = ^ir[3:0];

    // Undefined arithmetic encodings (0111, 1100, 1110) neither write nor
    // touch the flags. CMP only updates flags; OUT and HLT do neither.
    always_comb begin
        alu_wr = 1'b0;
        alu_fl = 1'b0;
        case (op3)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                alu_wr = 1'b1;
                alu_fl = 1'b1;
            end
            4'b0101: alu_fl = 1'b1;
            default: ;
        endcase
    end

    // Condition test uses flags left by earlier instructions, flags = {S,Z,C,V}.
    always_comb begin
        case (ir[10:8])
            3'b000:  cond_met = flags[2];
            3'b001:  cond_met = flags[3] ^ flags[0];
            3'b010:  cond_met = flags[2] | (flags[3] ^ flags[0]);
            3'b011:  cond_met = ~flags[2];
            default: cond_met = 1'b0;
        endcase
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALT: if (start) state_next = P1;
            P1:         state_next = P2;
            P2:         state_next = P3;
            P3:         state_next = is_hlt ? HALT : P4;
            P4:         state_next = P5;
`ifdef PHASE_CONTROL_SINGLE_STEP_EN
            P5:         state_next = STEP_WAIT;
            STEP_WAIT:  if (step) state_next = P1;
`else
            P5:         state_next = P1;
`endif
            default:    state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the branch decision below relies on seeing the
    // old flags even in the same edge that could update them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            flags <= 4'b0000;
            taken <= 1'b0;
        end else begin
            state <= state_next;
            if (state == P3) begin
                if (is_alu && alu_fl)
                    flags <= {s_in, z_in, c_in, v_in};
                taken <= is_b | (is_bc & cond_met);
            end
        end
    end

    // ---------------- output decode ----------------
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        phase     = 5'b00000;
        ir_e      = 1'b0;
        ar_e      = 1'b0;
        br_e      = 1'b0;
        dr_e      = 1'b0;
        mr_e      = 1'b0;
        pc_e      = 1'b0;
        pc_ld     = 1'b0;
        alu_e     = 1'b0;
        mem_e     = 1'b0;
        reg_read  = 1'b0;
        reg_write = 1'b0;
        m1_s      = 1'b0;
        m2_s      = 1'b0;
        m3_s      = 1'b0;
        m4_s      = 1'b0;
        alu_cnt   = 4'b0000;
        halted    = (state == HALT);
        case (state)
            P1: begin
                phase = 5'b00001;
                ir_e  = 1'b1;
                pc_e  = 1'b1;
            end
            P2: begin
                phase    = 5'b00010;
                reg_read = 1'b1;
                ar_e     = 1'b1;
                br_e     = 1'b1;
                m2_s     = is_b | is_bc;
                m3_s     = is_ld | is_st | is_li | is_b | is_bc;
            end
            P3: begin
                phase = 5'b00100;
                alu_e = 1'b1;
                dr_e  = 1'b1;
                if (is_alu)     alu_cnt = op3;
                else if (is_li) alu_cnt = 4'b0110;
            end
            P4: begin
                phase = 5'b01000;
                mr_e  = is_ld;
                mem_e = is_st;
                m1_s  = is_ld | is_st;
                pc_e  = taken;
                pc_ld = taken;
            end
            P5: begin
                phase     = 5'b10000;
                reg_write = (is_alu & alu_wr) | is_li | is_ld;
                m4_s      = is_ld;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_phase_control.sv
// ---------------------------------------------------------------------------
// tb_phase_control
//   Self-checking bench for phase_control. Drives directed and random
//   instructions and compares every output, every phase, against a
//   behavioural model of the instruction set kept in this file.
// ---------------------------------------------------------------------------
module tb_phase_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
`ifdef PHASE_CONTROL_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [15:0] ir;
    logic        s_in, z_in, c_in, v_in;
    logic [4:0]  phase;
    logic        ir_e, ar_e, br_e, dr_e, mr_e, pc_e, pc_ld, alu_e, mem_e;
    logic        reg_read, reg_write, m1_s, m2_s, m3_s, m4_s, halted;
    logic [3:0]  alu_cnt, flags;

    phase_control dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef PHASE_CONTROL_SINGLE_STEP_EN
        .step(step),
`endif
        .ir(ir), .s_in(s_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
        .phase(phase), .ir_e(ir_e), .ar_e(ar_e), .br_e(br_e), .dr_e(dr_e),
        .mr_e(mr_e), .pc_e(pc_e), .pc_ld(pc_ld), .alu_e(alu_e), .mem_e(mem_e),
        .reg_read(reg_read), .reg_write(reg_write), .m1_s(m1_s), .m2_s(m2_s),
        .m3_s(m3_s), .m4_s(m4_s), .alu_cnt(alu_cnt), .flags(flags),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // All outputs packed in one fixed order for whole-vector comparison.
    logic [28:0] obs;
    assign obs = {phase, ir_e, ar_e, br_e, dr_e, mr_e, pc_e, pc_ld, alu_e,
                  mem_e, reg_read, reg_write, m1_s, m2_s, m3_s, m4_s,
                  alu_cnt, flags, halted};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_NOP, K_ALU, K_LD, K_ST, K_LI, K_B, K_BC} kind_e;

    logic [3:0] m_flags;   // architectural {S,Z,C,V}
    bit         m_taken;   // branch outcome of the current instruction

    function automatic kind_e classify(input logic [15:0] i);
        if (i[15:14] == 2'b11) return K_ALU;
        if (i[15:14] == 2'b00) return K_LD;
        if (i[15:14] == 2'b01) return K_ST;
        if (i[15:11] == 5'b10000) return K_LI;
        if (i[15:11] == 5'b10100) return K_B;
        if (i[15:11] == 5'b10111) return K_BC;
        return K_NOP;
    endfunction

    function automatic bit is_halt(input logic [15:0] i);
        return classify(i) == K_ALU && i[7:4] == 4'd15;
    endfunction

    // Defined ALU ops that update flags: ADD..CMP, MOV, shifts.
    function automatic bit sets_flags(input logic [15:0] i);
        int op = int'(i[7:4]);
        return classify(i) == K_ALU && (op inside {[0:6], [8:11]});
    endfunction

    function automatic bit writes_rf(input logic [15:0] i);
        int op = int'(i[7:4]);
        kind_e k = classify(i);
        if (k == K_LD || k == K_LI) return 1'b1;
        return k == K_ALU && (op inside {[0:4], 6, [8:11]});
    endfunction

    function automatic bit branch_taken(input logic [15:0] i, input logic [3:0] f);
        bit s = f[3], z = f[2], v = f[0];
        if (classify(i) == K_B) return 1'b1;
        if (classify(i) != K_BC) return 1'b0;
        case (int'(i[10:8]))
            0: return z;
            1: return s ^ v;
            2: return z | (s ^ v);
            3: return !z;
            default: return 1'b0;
        endcase
    endfunction

    // Expected output vector; p = 1..5 for a phase, 0 when idle/halted.
    function automatic logic [28:0] model_out(input int p, input logic [15:0] i,
                                              input logic [3:0] fl, input bit tk,
                                              input bit hl);
        kind_e k = classify(i);
        logic [4:0] ph = (p == 0) ? 5'd0 : 5'(1 << (p - 1));
        logic ire = 0, are = 0, bre = 0, dre = 0, mre = 0, pce = 0, pcl = 0;
        logic alue = 0, meme = 0, rr = 0, rw = 0, s1 = 0, s2 = 0, s3 = 0, s4 = 0;
        logic [3:0] ac = 4'd0;
        case (p)
            1: begin ire = 1; pce = 1; end
            2: begin
                rr = 1; are = 1; bre = 1;
                s2 = (k == K_B || k == K_BC);
                s3 = (k != K_ALU && k != K_NOP);
            end
            3: begin
                alue = 1; dre = 1;
                ac = (k == K_ALU) ? i[7:4] : (k == K_LI) ? 4'd6 : 4'd0;
            end
            4: begin
                mre  = (k == K_LD);
                meme = (k == K_ST);
                s1   = (k == K_LD || k == K_ST);
                pce  = tk; pcl = tk;
            end
            5: begin rw = writes_rf(i); s4 = (k == K_LD); end
            default: ;
        endcase
        return {ph, ire, are, bre, dre, mre, pce, pcl, alue, meme, rr, rw,
                s1, s2, s3, s4, ac, fl, hl};
    endfunction

    // ---------------- stimulus ----------------
    // Called with the DUT about to enter P1 on the next rising edge.
    task automatic exec(input logic [15:0] iv, input logic [3:0] fin);
        for (int p = 1; p <= 5; p++) begin
            @(negedge clk);
            ir = iv;
            {s_in, z_in, c_in, v_in} = fin;
            start = (p == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            #1 check($sformatf("p%0d_ir%h", p, iv), 32'(obs),
                     32'(model_out(p, iv, m_flags, m_taken, 1'b0)));
            if (p == 3) begin
                m_taken = branch_taken(iv, m_flags);
                if (sets_flags(iv)) m_flags = fin;
                if (is_halt(iv)) begin
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        start = 1'b0;
                        ir = 16'($urandom);
                        #1 check("halt_hold", 32'(obs),
                                 32'(model_out(0, ir, m_flags, 1'b0, 1'b1)));
                    end
                    @(negedge clk);
                    start = 1'b1;   // resume at P1 on the next edge
                    return;
                end
            end
        end
    endtask

    function automatic logic [15:0] rand_ir();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r[15:14] = 2'b11;
            1: r[15:14] = 2'b00;
            2: r[15:14] = 2'b01;
            3: r[15:11] = 5'b10000;
            4: r[15:11] = 5'b10100;
            5: r[15:11] = 5'b10111;
            default: r[15:14] = 2'b10;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; ir = 16'h0000;
        {s_in, z_in, c_in, v_in} = 4'b0000;
        m_flags = 4'b0000; m_taken = 1'b0;

        #12 check("reset_outputs", 32'(obs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("idle_outputs", 32'(obs), 32'd0);
        @(negedge clk);
        start = 1'b1;
        #1 check("idle_start_sampled", 32'(obs), 32'd0);

        // Directed sequence.
        exec(16'hC000, 4'b0000);                // ADD
        exec(16'hC050, 4'b0100);                // CMP, Z=1
        check("cmp_flags", 32'(flags), 32'(4'b0100));
        exec(16'hB800, 4'b0000);                // BE, taken
        exec(16'hC050, 4'b0000);                // CMP, Z=0
        exec(16'hB800, 4'b0100);                // BE, not taken
        exec(16'h0000, 4'b1111);                // LD
        exec(16'h4000, 4'b1111);                // ST
        exec(16'h8012, 4'b1111);                // LI
        exec(16'hC0D0, 4'b1010);                // OUT, flags unchanged
        exec(16'hC0F0, 4'b1111);                // HLT

        // Random instruction stream.
        for (int n = 0; n < 80; n++)
            exec(rand_ir(), 4'($urandom));

        // Reset in the middle of P3.
        for (int p = 1; p <= 3; p++) begin
            @(negedge clk);
            ir = 16'hC000; start = 1'b0;
            {s_in, z_in, c_in, v_in} = 4'b1111;
        end
        #1 check("pre_rst_p3", 32'(obs),
                 32'(model_out(3, 16'hC000, m_flags, m_taken, 1'b0)));
        #1 rst = 1'b1;
        #1 check("rst_async", 32'(obs), 32'd0);
        m_flags = 4'b0000; m_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_idle", 32'(obs), 32'd0);
        @(negedge clk);
        start = 1'b1;
        exec(16'hC010, 4'b1001);
        check("post_rst_flags", 32'(flags), 32'(4'b1001));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
